// File: rtl/bp_pkg.sv
// Shared types and constants for the layer back-propagation sequencer.
package bp_pkg;

  localparam int BP_N_IN = 32;
  localparam int BP_WORD = 32;

  typedef logic [BP_WORD-1:0]             bp_word_t;
  typedef logic [BP_N_IN-1:0][BP_WORD-1:0] bp_dsvec_t;
  typedef logic [BP_N_IN:0][BP_WORD-1:0]   bp_wvec_t;
  typedef logic [63:0]                     bp_err_t;

  typedef enum logic [2:0] {
    BP_IDLE,
    BP_RD,
    BP_LD,
    BP_EX,
    BP_WR,
    BP_DONE
  } bp_seq_state_e;

  // Neuron index width; a one-neuron layer still gets a 1-bit address.
  function automatic int bp_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bp_layer_sequencer_if.sv
// Layer weight/error memory port. The sequencer is the master; memory is the slave.
interface bp_layer_sequencer_if
  import bp_pkg::*;
#(
  parameter int NEURONS = 8
) ();

  localparam int AW = bp_aw(NEURONS);

  logic           mem_ren;
  logic [AW-1:0]  mem_raddr;
  bp_wvec_t       mem_rdata_w;
  bp_err_t        mem_rdata_err;
  logic           mem_wen;
  logic [AW-1:0]  mem_waddr;
  bp_wvec_t       mem_wdata;

  modport master (
    output mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata,
    input  mem_rdata_w, mem_rdata_err
  );

  modport slave (
    input  mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata,
    output mem_rdata_w, mem_rdata_err
  );

endinterface

// File: rtl/bp_bc_accumulator.sv
// 32-lane accumulator for back-propagated contributions.
// Build option BP_BC_SAT_EN: lanes saturate to the signed 32-bit range
// instead of wrapping modulo 2^32.
module bp_bc_accumulator
  import bp_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      clr,
  input  logic      add,
  input  bp_dsvec_t bc,
  output bp_dsvec_t sum
);

  function automatic bp_word_t lane_add(input bp_word_t a, input bp_word_t b);
    bp_word_t s;
    s = a + b;
`ifdef BP_BC_SAT_EN
    // Overflow only when both operands share a sign the result lost.
    if ((a[BP_WORD-1] == b[BP_WORD-1]) && (s[BP_WORD-1] != a[BP_WORD-1]))
      s = a[BP_WORD-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return s;
  endfunction

  // Clear on a new pass, otherwise add one neuron's contributions per WR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (add) begin
      for (int i = 0; i < BP_N_IN; i++)
        sum[i] <= lane_add(sum[i], bc[i]);
    end
  end

endmodule

// File: rtl/bp_layer_sequencer.sv
// Time-shares one combinational back-prop datapath across all neurons of a
// layer: read weights/error, settle the datapath, write new weights back and
// accumulate per-input contributions for the previous layer.
// Build option BP_BC_SAT_EN selects saturating contribution sums (see
// bp_bc_accumulator); latency is the same either way.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | waiting for start; latches tm/td/ds and clears bc_sum
//   RD      | mem_ren with mem_raddr = idx
//   LD      | capture read weights and error into operand registers
//   EX      | datapath settles; capture new weights and contributions
//   WR      | mem_wen at idx, bc_sum += bc; next neuron or finish
//   DONE    | one-cycle done pulse
module bp_layer_sequencer
  import bp_pkg::*;
#(
  parameter int NEURONS = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      start,
  input  bp_word_t  tm_in,
  input  bp_word_t  td_in,
  input  bp_dsvec_t ds_in,
  output logic      busy,
  output logic      done,
  bp_layer_sequencer_if.master mem,
  output bp_dsvec_t dp_ds,
  output bp_wvec_t  dp_w,
  output bp_err_t   dp_bp,
  output bp_word_t  dp_tm,
  output bp_word_t  dp_td,
  input  bp_dsvec_t dp_bc,
  input  bp_wvec_t  dp_wn,
  output bp_dsvec_t bc_sum
);

  localparam int            AW       = bp_aw(NEURONS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NEURONS - 1);

  bp_seq_state_e state;
  logic [AW-1:0] idx;
  bp_dsvec_t     ds_q;
  bp_word_t      tm_q;
  bp_word_t      td_q;
  bp_wvec_t      w_q;
  bp_err_t       err_q;
  bp_dsvec_t     bc_q;

  logic acc_clr;
  logic acc_add;

  // Datapath operands come straight from the holding registers.
  assign dp_ds = ds_q;
  assign dp_tm = tm_q;
  assign dp_td = td_q;
  assign dp_w  = w_q;
  assign dp_bp = err_q;

  assign acc_clr = (state == BP_IDLE) && start;
  assign acc_add = (state == BP_WR);

  // Sequencer FSM; all strobes and addresses are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= BP_IDLE;
      idx            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      mem.mem_ren    <= 1'b0;
      mem.mem_raddr  <= '0;
      mem.mem_wen    <= 1'b0;
      mem.mem_waddr  <= '0;
      mem.mem_wdata  <= '0;
      ds_q           <= '0;
      tm_q           <= '0;
      td_q           <= '0;
      w_q            <= '0;
      err_q          <= '0;
      bc_q           <= '0;
    end else begin
      case (state)
        BP_IDLE: begin
          done <= 1'b0;
          if (start) begin
            ds_q          <= ds_in;
            tm_q          <= tm_in;
            td_q          <= td_in;
            idx           <= '0;
            busy          <= 1'b1;
            mem.mem_ren   <= 1'b1;
            mem.mem_raddr <= '0;
            state         <= BP_RD;
          end
        end
        BP_RD: begin
          mem.mem_ren <= 1'b0;
          state       <= BP_LD;
        end
        BP_LD: begin
          w_q   <= mem.mem_rdata_w;
          err_q <= mem.mem_rdata_err;
          state <= BP_EX;
        end
        BP_EX: begin
          mem.mem_wdata <= dp_wn;
          bc_q          <= dp_bc;
          mem.mem_wen   <= 1'b1;
          mem.mem_waddr <= idx;
          state         <= BP_WR;
        end
        BP_WR: begin
          mem.mem_wen <= 1'b0;
          if (idx == LAST_IDX) begin
            done  <= 1'b1;
            state <= BP_DONE;
          end else begin
            idx           <= idx + AW'(1);
            mem.mem_ren   <= 1'b1;
            mem.mem_raddr <= idx + AW'(1);
            state         <= BP_RD;
          end
        end
        BP_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= BP_IDLE;
        end
        default: state <= BP_IDLE;
      endcase
    end
  end

  bp_bc_accumulator u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .add   (acc_add),
    .bc    (bc_q),
    .sum   (bc_sum)
  );

endmodule

// File: tb/tb_bp_layer_sequencer.sv
// Bench for bp_layer_sequencer: an 8-neuron and a 1-neuron instance, each
// with a behavioural weight/error memory and the wn=w+1, bc=ds datapath stub.
module tb_bp_layer_sequencer;
  import bp_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total_cnt = 0;
  int pass_cnt  = 0;

  // ---------------- 8-neuron instance ----------------
  logic      start8 = 1'b0;
  bp_word_t  tm8 = '0, td8 = '0;
  bp_dsvec_t ds8 = '0;
  logic      busy8, done8;
  bp_dsvec_t dp_ds8, dp_bc8, bc_sum8;
  bp_wvec_t  dp_w8, dp_wn8;
  bp_err_t   dp_bp8;
  bp_word_t  dp_tm8, dp_td8;

  bp_layer_sequencer_if #(.NEURONS(8)) if8 ();

  bp_layer_sequencer #(.NEURONS(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .tm_in(tm8), .td_in(td8),
    .ds_in(ds8), .busy(busy8), .done(done8), .mem(if8.master),
    .dp_ds(dp_ds8), .dp_w(dp_w8), .dp_bp(dp_bp8), .dp_tm(dp_tm8),
    .dp_td(dp_td8), .dp_bc(dp_bc8), .dp_wn(dp_wn8), .bc_sum(bc_sum8)
  );

  always_comb begin
    for (int k = 0; k <= BP_N_IN; k++) dp_wn8[k] = dp_w8[k] + 32'd1;
    dp_bc8 = dp_ds8;
  end

  bp_wvec_t img8[8];
  bp_wvec_t mem8[8];
  bp_err_t  err8[8];
  bp_err_t  bp_at_wr8[8];
  logic     load8 = 1'b0;
  int       wr_cnt8 = 0, done_cnt8 = 0, clash_cnt = 0;

  always @(posedge clk) begin
    if (load8) mem8 <= img8;
    else if (if8.mem_wen) begin
      mem8[if8.mem_waddr]      <= if8.mem_wdata;
      bp_at_wr8[if8.mem_waddr] <= dp_bp8;
    end
    if (if8.mem_wen) wr_cnt8 <= wr_cnt8 + 1;
    if (if8.mem_ren) begin
      if8.mem_rdata_w   <= mem8[if8.mem_raddr];
      if8.mem_rdata_err <= err8[if8.mem_raddr];
    end
    if (if8.mem_ren && if8.mem_wen) clash_cnt <= clash_cnt + 1;
    if (done8) done_cnt8 <= done_cnt8 + 1;
  end

  // ---------------- 1-neuron instance ----------------
  logic      start1 = 1'b0;
  bp_word_t  tm1 = '0, td1 = '0;
  bp_dsvec_t ds1 = '0;
  logic      busy1, done1;
  bp_dsvec_t dp_ds1, dp_bc1, bc_sum1;
  bp_wvec_t  dp_w1, dp_wn1;
  bp_err_t   dp_bp1;
  bp_word_t  dp_tm1, dp_td1;

  bp_layer_sequencer_if #(.NEURONS(1)) if1 ();

  bp_layer_sequencer #(.NEURONS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .tm_in(tm1), .td_in(td1),
    .ds_in(ds1), .busy(busy1), .done(done1), .mem(if1.master),
    .dp_ds(dp_ds1), .dp_w(dp_w1), .dp_bp(dp_bp1), .dp_tm(dp_tm1),
    .dp_td(dp_td1), .dp_bc(dp_bc1), .dp_wn(dp_wn1), .bc_sum(bc_sum1)
  );

  always_comb begin
    for (int k = 0; k <= BP_N_IN; k++) dp_wn1[k] = dp_w1[k] + 32'd1;
    dp_bc1 = dp_ds1;
  end

  bp_wvec_t img1;
  bp_wvec_t mem1;
  logic     load1 = 1'b0;
  int       wr_cnt1 = 0;
  logic     last_wa1 = 1'b1;

  always @(posedge clk) begin
    if (load1) mem1 <= img1;
    else if (if1.mem_wen) mem1 <= if1.mem_wdata;
    if (if1.mem_wen) begin
      wr_cnt1  <= wr_cnt1 + 1;
      last_wa1 <= if1.mem_waddr;
    end
    if (if1.mem_ren) begin
      if1.mem_rdata_w   <= mem1;
      if1.mem_rdata_err <= 64'h0123_4567_89AB_CDEF;
    end
    if (if1.mem_ren && if1.mem_wen) clash_cnt <= clash_cnt + 1;
  end

  // ---------------- reference model and helpers ----------------
  // Expected contribution sum after n neurons each contributing d.
  function automatic bp_word_t model_bc(input bp_word_t d, input int n);
    longint acc = 0;
    for (int j = 0; j < n; j++) begin
      acc = acc + longint'(signed'(d));
`ifdef BP_BC_SAT_EN
      if (acc > 64'sd2147483647) acc = 64'sd2147483647;
      if (acc < -64'sd2147483648) acc = -64'sd2147483648;
`else
      acc = longint'(signed'(acc[31:0]));
`endif
    end
    return acc[31:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_mem8(input int updated);
    bp_word_t e;
    for (int n = 0; n < 8; n++)
      for (int k = 0; k <= BP_N_IN; k++) begin
        e = (n < updated) ? img8[n][k] + 32'd1 : img8[n][k];
        check($sformatf("mem8_n%0d_k%0d", n, k), {32'd0, mem8[n][k]}, {32'd0, e});
      end
  endtask

  task automatic load_mem8();
    @(negedge clk); load8 = 1'b1;
    @(negedge clk); load8 = 1'b0;
  endtask

  // Start a pass on the 8-neuron DUT; inputs are scrambled after acceptance.
  task automatic run8(input bit poke, output int lat);
    int cnt;
    @(negedge clk); start8 = 1'b1;
    @(negedge clk); start8 = 1'b0; cnt = 1;
    check("busy8_first_cycle", {63'd0, busy8}, 64'd1);
    tm8 = $urandom; td8 = $urandom;
    for (int i = 0; i < BP_N_IN; i++) ds8[i] = $urandom;
    while (done8 !== 1'b1 && cnt < 200) begin
      start8 = poke && (cnt == 3 || cnt == 10);
      @(negedge clk); cnt++;
    end
    start8 = 1'b0;
    lat = cnt;
  endtask

  task automatic post8(input bp_dsvec_t ds_s, input bp_word_t tm_s, input bp_word_t td_s, input int lat);
    check("latency8", lat, 33);
    check("done8_pulse", {63'd0, done8}, 64'd1);
    check("dp_tm8", {32'd0, dp_tm8}, {32'd0, tm_s});
    check("dp_td8", {32'd0, dp_td8}, {32'd0, td_s});
    for (int i = 0; i < BP_N_IN; i++) begin
      check($sformatf("bc_sum8_%0d", i), {32'd0, bc_sum8[i]}, {32'd0, model_bc(ds_s[i], 8)});
      check($sformatf("dp_ds8_%0d", i), {32'd0, dp_ds8[i]}, {32'd0, ds_s[i]});
    end
    for (int n = 0; n < 8; n++)
      check($sformatf("bp_at_wr8_%0d", n), bp_at_wr8[n], err8[n]);
    @(negedge clk);
    check("busy8_after_done", {63'd0, busy8}, 64'd0);
    check("done8_after_done", {63'd0, done8}, 64'd0);
    check_mem8(8);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bp_dsvec_t ds_s;
    bp_word_t  tm_s, td_s;
    int        lat, wr0, dn0, cnt;

    repeat (3) @(negedge clk);
    check("rst_busy8", {63'd0, busy8}, 64'd0);
    check("rst_done8", {63'd0, done8}, 64'd0);
    check("rst_raddr8", {61'd0, if8.mem_raddr}, 64'd0);
    check("rst_wdata8_0", {32'd0, if8.mem_wdata[0]}, 64'd0);
    check("rst_dp_bp8", dp_bp8, 64'd0);
    check("rst_bc_sum8_0", {32'd0, bc_sum8[0]}, 64'd0);
    rst_n = 1'b1;

    // Idle after reset: nothing moves.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("idle_strobes", {60'd0, if8.mem_ren, if8.mem_wen, if1.mem_ren, if1.mem_wen}, 64'd0);
      check("idle_busy_done", {60'd0, busy8, done8, busy1, done1}, 64'd0);
    end

    // Directed pass: w = n*100+k, ds[i] = i.
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k <= BP_N_IN; k++) img8[n][k] = n * 100 + k;
      err8[n] = {$urandom, $urandom};
    end
    load_mem8();
    for (int i = 0; i < BP_N_IN; i++) ds8[i] = i;
    tm8 = 32'hA5A5_0001; td8 = 32'h5A5A_0002;
    ds_s = ds8; tm_s = tm8; td_s = td8; wr0 = wr_cnt8;
    run8(1'b0, lat);
    post8(ds_s, tm_s, td_s, lat);
    check("writes_directed", wr_cnt8 - wr0, 8);

    // Randomized passes; the second re-pulses start mid-pass.
    for (int p = 0; p < 3; p++) begin
      for (int n = 0; n < 8; n++) begin
        for (int k = 0; k <= BP_N_IN; k++) img8[n][k] = $urandom;
        err8[n] = {$urandom, $urandom};
      end
      load_mem8();
      for (int i = 0; i < BP_N_IN; i++) ds8[i] = $urandom;
      if (p == 2) ds8[0] = 32'h4000_0000;
      tm8 = $urandom; td8 = $urandom;
      ds_s = ds8; tm_s = tm8; td_s = td8; wr0 = wr_cnt8; dn0 = done_cnt8;
      run8(p == 1, lat);
      post8(ds_s, tm_s, td_s, lat);
      repeat (40) @(negedge clk);
      check("writes_per_pass", wr_cnt8 - wr0, 8);
      check("dones_per_pass", done_cnt8 - dn0, 1);
      check("busy8_quiet", {63'd0, busy8}, 64'd0);
    end

    // Reset after the third write of a pass.
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k <= BP_N_IN; k++) img8[n][k] = n * 100 + k;
      err8[n] = {$urandom, $urandom};
    end
    load_mem8();
    wr0 = wr_cnt8;
    @(negedge clk); start8 = 1'b1;
    @(negedge clk); start8 = 1'b0; cnt = 0;
    while (wr_cnt8 - wr0 < 3 && cnt < 200) begin
      @(negedge clk); cnt++;
    end
    check("reset_wait_writes", wr_cnt8 - wr0, 3);
    check("busy8_before_reset", {63'd0, busy8}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("busy8_in_reset", {63'd0, busy8}, 64'd0);
    check("wen8_in_reset", {63'd0, if8.mem_wen}, 64'd0);
    check("bc_sum8_in_reset", {32'd0, bc_sum8[5]}, 64'd0);
    repeat (3) @(negedge clk);
    check("writes_after_reset", wr_cnt8 - wr0, 3);
    check_mem8(3);
    rst_n = 1'b1;

    // Single-neuron layer.
    for (int k = 0; k <= BP_N_IN; k++) img1[k] = $urandom;
    @(negedge clk); load1 = 1'b1;
    @(negedge clk); load1 = 1'b0;
    for (int i = 0; i < BP_N_IN; i++) ds1[i] = $urandom;
    ds_s = ds1; wr0 = wr_cnt1;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0; cnt = 1;
    while (done1 !== 1'b1 && cnt < 50) begin
      @(negedge clk); cnt++;
    end
    check("latency1", cnt, 5);
    for (int i = 0; i < BP_N_IN; i++)
      check($sformatf("bc_sum1_%0d", i), {32'd0, bc_sum1[i]}, {32'd0, model_bc(ds_s[i], 1)});
    repeat (10) @(negedge clk);
    check("writes1", wr_cnt1 - wr0, 1);
    check("waddr1", {63'd0, last_wa1}, 64'd0);
    for (int k = 0; k <= BP_N_IN; k++)
      check($sformatf("mem1_k%0d", k), {32'd0, mem1[k]}, {32'd0, img1[k] + 32'd1});
    check("busy1_end", {63'd0, busy1}, 64'd0);

    check("ren_wen_clash", clash_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
